// File: rtl/is_uart_rx.sv
// 8N1 UART receiver with a self-generated oversample tick and a single-entry
// valid/ready holding register; reports framing errors and overruns as pulses.
module is_uart_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OS_RATE     = 16,
  parameter int DATA_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  localparam int DIV   = (CLK_FREQ_HZ + (BAUD_RATE * OS_RATE) / 2) / (BAUD_RATE * OS_RATE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OS_RATE);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        sync_q, sync_d;
  logic              rx_prev_q, rx_prev_d;
  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              fe_q, fe_d;
  logic              ovr_q, ovr_d;

  logic rx_s;
  logic fall;
  logic tick;

  assign rx_s = sync_q[1];
  assign fall = rx_prev_q & ~rx_s;
  assign tick = (state_q != S_IDLE) && (div_q == DIV_LAST);

  always_comb begin
    sync_d    = {sync_q[0], rx_i};
    rx_prev_d = rx_s;
    state_d   = state_q;
    div_d     = div_q;
    os_d      = os_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ovr_d     = 1'b0;

    if (state_q == S_IDLE || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_ONE;
    end

    if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          os_d    = '0;
          div_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (os_q == OS_HALF) begin
            os_d    = '0;
            bit_d   = '0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            os_d = os_q + OS_ONE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d    = '0;
            shift_d = {rx_s, shift_q[DATA_W-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            os_d = os_q + OS_ONE;
          end
        end
      end
      default: begin
        // Leaving at the stop-bit centre lets a back-to-back start edge be caught.
        if (tick) begin
          if (os_q == OS_LAST) begin
            os_d    = '0;
            state_d = S_IDLE;
            if (!rx_s) begin
              fe_d = 1'b1;
            end else if (!valid_q || rx_ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            os_d = os_q + OS_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      div_q     <= '0;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      div_q     <= div_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign frame_err_o = fe_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_is_uart_rx.sv
// Bench for is_uart_rx: table of frames plus hand-written corner sequences,
// with a scoreboard of expected deliveries, framing errors and overruns.
module tb_is_uart_rx;

  localparam int K_BYTE = 0;
  localparam int K_FE   = 1;
  localparam int K_OVR  = 2;
  localparam int LAT    = 3 + 16 + 9 * 32;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bitcyc;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic       rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overrun_o;

  int   cyc = 0;
  int   fall_cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  ev_t  sb[$];
  vec_t vecs[6];
  logic prev_valid = 1'b0;
  logic prev_accept = 1'b0;

  is_uart_rx #(
    .CLK_FREQ_HZ(3_200_000),
    .BAUD_RATE  (100_000),
    .OS_RATE    (16),
    .DATA_W     (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic stop, input int bc);
    rx_i = 1'b0;
    fall_cyc = cyc;
    wait_cycles(bc);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      wait_cycles(bc);
    end
    rx_i = stop;
    wait_cycles(bc);
    rx_i = 1'b1;
  endtask

  task automatic check_event(input int kind, input logic [7:0] data);
    ev_t e;
    int  lat;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL unexpected_event: got kind %0d data 0x%0h, expected none at cycle %0d",
               kind, data, cyc);
    end else begin
      e = sb.pop_front();
      check_output("event_kind", kind, e.kind);
      if (kind == K_BYTE) check_output("rx_data", int'(data), int'(e.data));
      lat = cyc - fall_cyc;
      n_vec++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        n_miss++;
        $display("[TB] FAIL latency: got %0d cycles, expected %0d +/-1", lat, LAT);
      end
    end
  endtask

  // Every new byte in the holding register, error pulse and overrun pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid  <= 1'b0;
      prev_accept <= 1'b0;
    end else begin
      if (rx_valid_o && (!prev_valid || prev_accept)) check_event(K_BYTE, rx_data_o);
      if (frame_err_o) check_event(K_FE, 8'h00);
      if (overrun_o) check_event(K_OVR, 8'h00);
      prev_valid  <= rx_valid_o;
      prev_accept <= rx_valid_o && rx_ready_i;
    end
  end

  task automatic check_all_zero(input string tag);
    check_output({tag, "_data"}, int'(rx_data_o), 0);
    check_output({tag, "_valid"}, int'(rx_valid_o), 0);
    check_output({tag, "_busy"}, int'(busy_o), 0);
    check_output({tag, "_frame_err"}, int'(frame_err_o), 0);
    check_output({tag, "_overrun"}, int'(overrun_o), 0);
  endtask

  initial begin
    ev_t e;
    vecs[0] = '{8'hA5, 1'b1, 32, K_BYTE, 8'hA5};
    vecs[1] = '{8'hFF, 1'b0, 32, K_FE,   8'h00};
    vecs[2] = '{8'h55, 1'b1, 32, K_BYTE, 8'h55};
    vecs[3] = '{8'h00, 1'b1, 33, K_BYTE, 8'h00};
    vecs[4] = '{8'h7E, 1'b1, 32, K_BYTE, 8'h7E};
    vecs[5] = '{8'h01, 1'b1, 31, K_BYTE, 8'h01};

    rst = 1'b1;
    rx_i = 1'b1;
    rx_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(10);

    for (int i = 0; i < 6; i++) begin
      e.kind = vecs[i].exp_kind;
      e.data = vecs[i].exp_data;
      sb.push_back(e);
      apply_stimulus(vecs[i].data, vecs[i].stop, vecs[i].bitcyc);
      wait_cycles(30);
    end

    // A short low glitch starts a frame but is rejected at the start sample.
    rx_i = 1'b0;
    wait_cycles(10);
    rx_i = 1'b1;
    wait_cycles(2);
    @(negedge clk);
    check_output("glitch_busy_high", int'(busy_o), 1);
    wait_cycles(30);
    @(negedge clk);
    check_output("glitch_busy_low", int'(busy_o), 0);
    check_output("glitch_valid", int'(rx_valid_o), 0);

    rx_ready_i = 1'b0;
    e.kind = K_BYTE; e.data = 8'h3C; sb.push_back(e);
    apply_stimulus(8'h3C, 1'b1, 32);
    e.kind = K_OVR;  e.data = 8'h00; sb.push_back(e);
    apply_stimulus(8'hC3, 1'b1, 32);
    wait_cycles(20);
    @(negedge clk);
    check_output("overrun_data_kept", int'(rx_data_o), 8'h3C);
    check_output("overrun_valid_kept", int'(rx_valid_o), 1);
    wait_cycles(1);
    rx_ready_i = 1'b1;
    wait_cycles(1);
    rx_ready_i = 1'b0;
    @(negedge clk);
    check_output("accept_clears_valid", int'(rx_valid_o), 0);
    check_output("accept_data_kept", int'(rx_data_o), 8'h3C);
    wait_cycles(5);
    rx_ready_i = 1'b1;

    // Abort a 0x5A frame half way through data bit 4.
    rx_i = 1'b0;
    wait_cycles(32);
    for (int i = 0; i < 4; i++) begin
      rx_i = (i % 2 == 1) ? 1'b1 : 1'b0;
      wait_cycles(32);
    end
    rx_i = 1'b1;
    wait_cycles(16);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midframe_reset");
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(20);
    e.kind = K_BYTE; e.data = 8'h81; sb.push_back(e);
    apply_stimulus(8'h81, 1'b1, 32);
    wait_cycles(50);

    check_output("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
